// File: rtl/fir_tap_sequencer_pkg.sv
// Shared constants for the FIR tap sequencer: RAM geometry, FSM encoding
// and the circular-history address helper.
package fir_tap_sequencer_pkg;

   localparam int DW    = 14;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_SWEEP = 2'd3;

   // Address of the k-th newest sample; the 6-bit subtract wraps 0 -> 63.
   function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] wptr,
                                              input logic [AW-1:0] k);
      return wptr - k;
   endfunction

endpackage

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: owns a 64x14 circular sample history held in an external
// async-read RAM. Each accepted sample is written, then the newest TAPS samples
// are swept out newest-first as a strobed tap stream.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | zero-fill all 64 RAM words after reset, input not ready
//   IDLE  | ready for a sample; tap pipeline drains its final entry
//   WRITE | one cycle, latched sample written at wptr
//   SWEEP | present wptr-k for k = 0..TAPS-1, then advance wptr
//
// RAM_A/RAM_D/RAM_WE are registered and loaded together with the state they
// belong to, so the RAM sees exactly one write per WRITE cycle and the address
// of tap k is on the bus during the k-th SWEEP cycle.
module fir_tap_sequencer
   import fir_tap_sequencer_pkg::*;
#(
   parameter int TAPS = 64
)
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [DW-1:0] i_in_d,
   input  logic          i_in_stb,
   output logic          o_in_rdy,
   output logic [AW-1:0] o_ram_a,
   output logic [DW-1:0] o_ram_d,
   output logic          o_ram_we,
   input  logic [DW-1:0] i_ram_o,
   output logic [DW-1:0] o_tap_d,
   output logic [AW-1:0] o_tap_idx,
   output logic          o_tap_valid,
   output logic          o_tap_first,
   output logic          o_tap_last,
   output logic          o_ovr
);

   localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);

   logic [1:0]    r_state;
   logic [AW-1:0] r_wptr;
   logic [AW:0]   r_clr_cnt;
   logic [AW-1:0] r_k;
   logic [AW-1:0] r_ram_a;
   logic [DW-1:0] r_ram_d;
   logic          r_ram_we;
   logic [DW-1:0] r_tap_d;
   logic [AW-1:0] r_tap_idx;
   logic          r_tap_valid;
   logic          r_tap_first;
   logic          r_tap_last;
   logic          r_ovr;

   logic          w_in_sweep;
   logic          w_k_last;
   logic [AW-1:0] w_k_next;

   assign w_in_sweep = (r_state == ST_SWEEP);
   assign w_k_last   = (r_k == LAST_K);
   assign w_k_next   = r_k + AW'(1);

   // Sequencer FSM plus the registered RAM port it drives.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_CLEAR;
         r_wptr    <= '0;
         r_clr_cnt <= '0;
         r_k       <= '0;
         r_ram_a   <= '0;
         r_ram_d   <= '0;
         r_ram_we  <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               // Bit AW set means all 64 words have been presented.
               if (r_clr_cnt[AW]) begin
                  r_state  <= ST_IDLE;
                  r_ram_we <= 1'b0;
               end else begin
                  r_ram_we  <= 1'b1;
                  r_ram_a   <= r_clr_cnt[AW-1:0];
                  r_ram_d   <= '0;
                  r_clr_cnt <= r_clr_cnt + (AW+1)'(1);
               end
            end
            ST_IDLE: begin
               if (i_in_stb) begin
                  r_state  <= ST_WRITE;
                  r_ram_a  <= r_wptr;
                  r_ram_d  <= i_in_d;
                  r_ram_we <= 1'b1;
               end
            end
            ST_WRITE: begin
               r_state  <= ST_SWEEP;
               r_ram_we <= 1'b0;
               r_ram_a  <= r_wptr;
               r_k      <= '0;
            end
            ST_SWEEP: begin
               if (w_k_last) begin
                  r_state <= ST_IDLE;
                  r_wptr  <= r_wptr + AW'(1);
               end else begin
                  r_k     <= w_k_next;
                  r_ram_a <= tap_addr(r_wptr, w_k_next);
               end
            end
            default: begin
               r_state  <= ST_CLEAR;
               r_ram_we <= 1'b0;
            end
         endcase
      end
   end

   // Tap output register: captures the async RAM read for the address shown this cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tap_d     <= '0;
         r_tap_idx   <= '0;
         r_tap_valid <= 1'b0;
         r_tap_first <= 1'b0;
         r_tap_last  <= 1'b0;
      end else begin
         r_tap_valid <= w_in_sweep;
         r_tap_first <= w_in_sweep && (r_k == '0);
         r_tap_last  <= w_in_sweep && w_k_last;
         if (w_in_sweep) begin
            r_tap_d   <= i_ram_o;
            r_tap_idx <= r_k;
         end
      end
   end

   // Sticky overrun flag for strobes that arrive while not ready.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovr <= 1'b0;
      end else if (i_in_stb && (r_state != ST_IDLE)) begin
         r_ovr <= 1'b1;
      end
   end

   assign o_in_rdy    = (r_state == ST_IDLE);
   assign o_ram_a     = r_ram_a;
   assign o_ram_d     = r_ram_d;
   assign o_ram_we    = r_ram_we;
   assign o_tap_d     = r_tap_d;
   assign o_tap_idx   = r_tap_idx;
   assign o_tap_valid = r_tap_valid;
   assign o_tap_first = r_tap_first;
   assign o_tap_last  = r_tap_last;
   assign o_ovr       = r_ovr;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: a TAPS=64 instance and a TAPS=1
// instance, each with its own behavioural 64x14 async-read RAM.
module tb_fir_tap_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] in_d, in_d1;
   logic        stb, stb1;

   logic        in_rdy, ram_we, tap_valid, tap_first, tap_last, ovr;
   logic [5:0]  ram_a, tap_idx;
   logic [13:0] ram_d, ram_o, tap_d;

   logic        in_rdy1, ram_we1, tap_valid1, tap_first1, tap_last1, ovr1;
   logic [5:0]  ram_a1, tap_idx1;
   logic [13:0] ram_d1, ram_o1, tap_d1;

   logic [13:0] mem0 [64];
   logic [13:0] mem1 [64];

   logic [13:0] cap_d [64];
   logic [5:0]  cap_a [64];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fir_tap_sequencer #(.TAPS(64)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_in_d(in_d), .i_in_stb(stb), .o_in_rdy(in_rdy),
      .o_ram_a(ram_a), .o_ram_d(ram_d), .o_ram_we(ram_we), .i_ram_o(ram_o),
      .o_tap_d(tap_d), .o_tap_idx(tap_idx), .o_tap_valid(tap_valid),
      .o_tap_first(tap_first), .o_tap_last(tap_last), .o_ovr(ovr)
   );

   fir_tap_sequencer #(.TAPS(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_in_d(in_d1), .i_in_stb(stb1), .o_in_rdy(in_rdy1),
      .o_ram_a(ram_a1), .o_ram_d(ram_d1), .o_ram_we(ram_we1), .i_ram_o(ram_o1),
      .o_tap_d(tap_d1), .o_tap_idx(tap_idx1), .o_tap_valid(tap_valid1),
      .o_tap_first(tap_first1), .o_tap_last(tap_last1), .o_ovr(ovr1)
   );

   // Non-zero power-up contents so the zero-fill is observable.
   initial begin
      for (int i = 0; i < 64; i++) begin
         mem0[i] = 14'h2AAA;
         mem1[i] = 14'h2AAA;
      end
   end

   always @(posedge clk) begin
      if (ram_we)  mem0[ram_a]  <= ram_d;
      if (ram_we1) mem1[ram_a1] <= ram_d1;
   end

   assign ram_o  = mem0[ram_a];
   assign ram_o1 = mem1[ram_a1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe one sample on the current (ready) cycle of the TAPS=64 instance and
   // follow its WRITE and 64-tap sweep. Returns on the IN_RDY cycle after the last
   // tap, so a following call strobes at the minimum period. inj_k >= 0 injects an
   // illegal strobe during the sweep cycle that presents tap inj_k.
   task automatic sweep64(input logic [13:0] d, input logic [5:0] wp, input int inj_k);
      check("rdy_pre", 32'(in_rdy), 1);
      stb  = 1'b1;
      in_d = d;
      tick();
      stb = 1'b0;
      check("wr_we",  32'(ram_we), 1);
      check("wr_a",   32'(ram_a), 32'(wp));
      check("wr_d",   32'(ram_d), 32'(d));
      check("wr_rdy", 32'(in_rdy), 0);
      check("wr_tv",  32'(tap_valid), 0);
      tick();
      check("sw_tv0", 32'(tap_valid), 0);
      check("sw_we",  32'(ram_we), 0);
      cap_a[0] = ram_a;
      for (int k = 0; k < 64; k++) begin
         if (k == inj_k) begin
            stb  = 1'b1;
            in_d = 14'h3ABC;
         end
         tick();
         stb = 1'b0;
         check("tap_valid", 32'(tap_valid), 1);
         check("tap_idx",   32'(tap_idx), 32'(k));
         check("tap_first", 32'(tap_first), 32'(k == 0));
         check("tap_last",  32'(tap_last), 32'(k == 63));
         check("tap_rdy",   32'(in_rdy), 32'(k == 63));
         cap_d[k] = tap_d;
         if (k < 63) cap_a[k+1] = ram_a;
      end
   endtask

   initial begin
      bit found;
      rst   = 1'b1;
      stb   = 1'b0;
      stb1  = 1'b0;
      in_d  = '0;
      in_d1 = '0;

      // Reset values
      tick();
      check("rst_we",   32'(ram_we), 0);
      check("rst_a",    32'(ram_a), 0);
      check("rst_d",    32'(ram_d), 0);
      check("rst_rdy",  32'(in_rdy), 0);
      check("rst_tv",   32'(tap_valid), 0);
      check("rst_ovr",  32'(ovr), 0);
      rst = 1'b0;

      // Zero-fill: 64 write cycles, addresses 0..63, then ready at cycle 65
      for (int i = 1; i <= 64; i++) begin
         tick();
         check("clr_we",  32'(ram_we), 1);
         check("clr_a",   32'(ram_a), 32'(i - 1));
         check("clr_d",   32'(ram_d), 0);
         check("clr_rdy", 32'(in_rdy), 0);
      end
      tick();
      check("clr_done_rdy", 32'(in_rdy), 1);
      check("clr_done_we",  32'(ram_we), 0);
      check("clr_done_rdy1", 32'(in_rdy1), 1);

      // Single sample into a cleared history
      sweep64(14'h0123, 6'd0, -1);
      for (int k = 0; k < 64; k++) begin
         check("s1_tap_d", 32'(cap_d[k]), (k == 0) ? 32'h0123 : 32'h0);
         check("s1_ram_a", 32'(cap_a[k]), 32'((64 - k) % 64));
      end

      // 70 samples back-to-back at period 66; pointer wraps
      for (int i = 1; i <= 70; i++) sweep64(14'(i), 6'(i % 64), -1);
      for (int k = 0; k < 64; k++) begin
         check("wrap_tap_d", 32'(cap_d[k]), 32'(70 - k));
         check("wrap_ram_a", 32'(cap_a[k]), 32'((6 - k + 64) % 64));
      end
      check("wrap_a6",  32'(cap_a[6]), 0);
      check("wrap_a7",  32'(cap_a[7]), 63);
      tick();
      check("drain_tv", 32'(tap_valid), 0);

      // Overrun: strobe during sweep is dropped and flagged
      check("ovr_pre", 32'(ovr), 0);
      sweep64(14'h0AAA, 6'd7, 20);
      check("ovr_set", 32'(ovr), 1);
      sweep64(14'h0555, 6'd8, -1);
      check("ovr_tap0", 32'(cap_d[0]), 32'h0555);
      check("ovr_tap1", 32'(cap_d[1]), 32'h0AAA);
      check("ovr_tap2", 32'(cap_d[2]), 32'd70);
      check("ovr_sticky", 32'(ovr), 1);

      // Reset in the middle of a sweep, at tap 10
      stb  = 1'b1;
      in_d = 14'h0111;
      tick();
      stb   = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (tap_valid && (tap_idx == 6'd10)) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("mid_reach_tap10", 32'(found), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_tv",  32'(tap_valid), 0);
      check("mid_rst_we",  32'(ram_we), 0);
      check("mid_rst_ovr", 32'(ovr), 0);
      check("mid_rst_rdy", 32'(in_rdy), 0);
      for (int i = 1; i <= 64; i++) begin
         tick();
         check("reclr_we", 32'(ram_we), 1);
         check("reclr_a",  32'(ram_a), 32'(i - 1));
      end
      tick();
      check("reclr_rdy", 32'(in_rdy), 1);
      sweep64(14'h0222, 6'd0, -1);
      for (int k = 0; k < 64; k++)
         check("reclr_tap_d", 32'(cap_d[k]), (k == 0) ? 32'h0222 : 32'h0);

      // TAPS=1 instance
      check("t1_rdy_pre", 32'(in_rdy1), 1);
      stb1  = 1'b1;
      in_d1 = 14'h3FFF;
      tick();
      stb1 = 1'b0;
      check("t1_wr_we",  32'(ram_we1), 1);
      check("t1_wr_a",   32'(ram_a1), 0);
      check("t1_wr_rdy", 32'(in_rdy1), 0);
      tick();
      check("t1_tv0",    32'(tap_valid1), 0);
      tick();
      check("t1_tv",     32'(tap_valid1), 1);
      check("t1_first",  32'(tap_first1), 1);
      check("t1_last",   32'(tap_last1), 1);
      check("t1_idx",    32'(tap_idx1), 0);
      check("t1_tap_d",  32'(tap_d1), 32'h3FFF);
      check("t1_rdy",    32'(in_rdy1), 1);
      tick();
      check("t1_tv_end", 32'(tap_valid1), 0);
      check("t1_ovr",    32'(ovr1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
